// File: rtl/card_pos_loader_pkg.sv
// card_pos_loader_pkg: shared layout sizes, sentinel and FSM encoding for the card position loader
package card_pos_loader_pkg;
    localparam int N_SMALL   = 8;
    localparam int N_MID     = 12;
    localparam int N_LARGE   = 18;
    localparam int MAX_CARDS = 18;
    localparam logic [19:0] SENTINEL = {10'd1023, 10'd1023};
    typedef enum logic [2:0] {IDLE, REQ, WAIT, LOAD, READY, SCAN} state_t;
    function automatic logic legal_n(input logic [4:0] n);
        return n == 5'(N_SMALL) || n == 5'(N_MID) || n == 5'(N_LARGE);
    endfunction
endpackage

// File: rtl/card_pos_loader_if.sv
// card_pos_loader_if: control, ROM stream, mouse and result signals (hit_mask only with CARD_HIT_MASK_EN)
interface card_pos_loader_if;
    logic        load_start;
    logic [4:0]  num_of_cards;
    logic        rom_read_all;
    logic [19:0] rom_yx;
    logic        click;
    logic [9:0]  mouse_x;
    logic [9:0]  mouse_y;
    logic        layout_ready;
    logic        busy;
    logic        hit_valid;
    logic        hit_found;
    logic [4:0]  hit_index;
    logic        cfg_err;
`ifdef CARD_HIT_MASK_EN
    logic [17:0] hit_mask;
    modport slave (input load_start, num_of_cards, rom_yx, click, mouse_x, mouse_y, hit_mask,
                   output rom_read_all, layout_ready, busy, hit_valid, hit_found, hit_index, cfg_err);
    modport master (output load_start, num_of_cards, rom_yx, click, mouse_x, mouse_y, hit_mask,
                    input rom_read_all, layout_ready, busy, hit_valid, hit_found, hit_index, cfg_err);
`else
    modport slave (input load_start, num_of_cards, rom_yx, click, mouse_x, mouse_y,
                   output rom_read_all, layout_ready, busy, hit_valid, hit_found, hit_index, cfg_err);
    modport master (output load_start, num_of_cards, rom_yx, click, mouse_x, mouse_y,
                    input rom_read_all, layout_ready, busy, hit_valid, hit_found, hit_index, cfg_err);
`endif
endinterface

// File: rtl/card_pos_loader_hit_cmp.sv
// card_hit_cmp: combinational point-in-card test; sentinel and masked entries never hit
module card_hit_cmp import card_pos_loader_pkg::*; (
    input  logic [9:0]  pt_x,
    input  logic [9:0]  pt_y,
    input  logic [19:0] pos,
    input  logic [10:0] card_w,
    input  logic [10:0] card_h,
    input  logic        mask,
    output logic        hit
);
    logic [10:0] px, py, x, y;
    assign px = {1'b0, pos[9:0]};
    assign py = {1'b0, pos[19:10]};
    assign x = {1'b0, pt_x};
    assign y = {1'b0, pt_y};
    assign hit = !mask && pos != SENTINEL && x >= px && x < px + card_w && y >= py && y < py + card_h;
endmodule

// File: rtl/card_pos_loader.sv
// card_pos_loader: loads card positions from a streaming ROM and hit-tests mouse clicks (CARD_HIT_MASK_EN adds hit_mask)
module card_pos_loader import card_pos_loader_pkg::*; #(
    parameter int CARD_W      = 200,
    parameter int CARD_H      = 150,
    parameter int ROM_LATENCY = 2
) (
    input logic              clk,
    input logic              rst,
    card_pos_loader_if.slave bus
);
    state_t      state;
    logic [19:0] tbl [MAX_CARDS];
    logic [4:0]  n, idx;
    logic [7:0]  cnt;
    logic [9:0]  mx, my;
    logic        hit, masked;
`ifdef CARD_HIT_MASK_EN
    assign masked = bus.hit_mask[idx];
`else
    assign masked = 1'b0;
`endif
    assign bus.busy = state inside {REQ, WAIT, LOAD, SCAN};
    card_hit_cmp u_cmp (
        .pt_x   (mx),
        .pt_y   (my),
        .pos    (tbl[idx]),
        .card_w (11'(CARD_W)),
        .card_h (11'(CARD_H)),
        .mask   (masked),
        .hit    (hit)
    );
    // layout load sequencing, click scan and registered result/strobe outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            n <= '0;
            idx <= '0;
            cnt <= '0;
            mx <= '0;
            my <= '0;
            for (int i = 0; i < MAX_CARDS; i++) tbl[i] <= SENTINEL;
            bus.rom_read_all <= 1'b0;
            bus.layout_ready <= 1'b0;
            bus.hit_valid <= 1'b0;
            bus.hit_found <= 1'b0;
            bus.hit_index <= '0;
            bus.cfg_err <= 1'b0;
        end else begin
            bus.rom_read_all <= 1'b0;
            bus.hit_valid <= 1'b0;
            bus.cfg_err <= 1'b0;
            case (state)
                IDLE, READY: begin
                    if (bus.load_start) begin
                        if (legal_n(bus.num_of_cards)) begin
                            n <= bus.num_of_cards;
                            for (int i = 0; i < MAX_CARDS; i++) tbl[i] <= SENTINEL;
                            bus.layout_ready <= 1'b0;
                            bus.rom_read_all <= 1'b1;
                            state <= REQ;
                        end else begin
                            bus.cfg_err <= 1'b1;
                        end
                    end else if (state == READY && bus.click) begin
                        mx <= bus.mouse_x;
                        my <= bus.mouse_y;
                        idx <= '0;
                        state <= SCAN;
                    end
                end
                REQ: begin
                    idx <= '0;
                    cnt <= 8'(ROM_LATENCY - 2);
                    state <= ROM_LATENCY > 1 ? WAIT : LOAD;
                end
                WAIT: begin
                    if (cnt == '0) state <= LOAD;
                    else cnt <= cnt - 8'd1;
                end
                LOAD: begin
                    tbl[idx] <= bus.rom_yx;
                    if (idx == n - 5'd1) begin
                        bus.layout_ready <= 1'b1;
                        state <= READY;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                SCAN: begin
                    if (hit || idx == n - 5'd1) begin
                        bus.hit_valid <= 1'b1;
                        bus.hit_found <= hit;
                        bus.hit_index <= hit ? idx : '0;
                        state <= READY;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
